spin_sample_collector: RTL and testbench

- Produces the packed 7-sample-per-spin bus consumed by the majority vote stage.
- Repeatedly samples the asynchronous oscillator spin outputs of an Ising core, one sample every SAMPLE_INTERVAL clocks, 7 samples in total.
- Packs the results so that spin i's samples occupy bits [i*7 +: 7] of SPIN_SAMPLE.
- Sits between the core's phase-readout outputs and the majority vote stage, and is controlled by the readout controller through a START/DONE handshake.

---
 rtl/spin_sample_collector.sv | 137 +++++++++++++
 tb/tb_spin_sample_collector.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/spin_sample_collector.sv
// ============================================================================
// Module   : spin_sample_collector
// Brief    : Takes seven time-spaced samples of every asynchronous spin level
//            from the Ising core. Each spin level is first passed through a
//            two-flop synchronizer. The samples are packed so that spin i owns
//            bits [i*7 +: 7], which is the layout the majority-vote stage
//            expects. Collection starts on a START/DONE handshake.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module spin_sample_collector #(
  parameter int CORE_SIZE   = 64,
  parameter int NUM_SAMPLES = 7,   // the voter consumes exactly seven samples
  parameter int INTERVAL_W  = 16
) (
  input  logic                             CLK,
  input  logic                             RSTN,
  input  logic                             START,
  input  logic [INTERVAL_W-1:0]            SAMPLE_INTERVAL,
  input  logic [CORE_SIZE-1:0]             SPIN_IN,
  output logic [CORE_SIZE*NUM_SAMPLES-1:0] SPIN_SAMPLE,
  output logic                             BUSY,
  output logic                             DONE
);

  localparam int IDX_W = $clog2(NUM_SAMPLES);
  localparam logic [IDX_W-1:0]      c_LAST_IDX = IDX_W'(NUM_SAMPLES - 1);
  localparam logic [INTERVAL_W-1:0] c_ONE      = INTERVAL_W'(1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t                           r_state;
  logic [CORE_SIZE-1:0]             r_sync1;
  logic [CORE_SIZE-1:0]             r_sync2;
  logic [CORE_SIZE*NUM_SAMPLES-1:0] r_sample;
  logic [INTERVAL_W-1:0]            r_cnt;
  logic [INTERVAL_W-1:0]            r_n;
  logic [IDX_W-1:0]                 r_idx;
  logic                             r_busy;
  logic                             r_done;

  logic [INTERVAL_W-1:0]            w_eff_n;
  logic [CORE_SIZE*NUM_SAMPLES-1:0] w_sample_cap;

  // A programmed interval of zero is treated as one clock.
  assign w_eff_n = (SAMPLE_INTERVAL == '0) ? c_ONE : SAMPLE_INTERVAL;

  // Next sample vector: slot r_idx of every spin takes its synchronized
  // level. All other slots keep their current contents.
  for (genvar i = 0; i < CORE_SIZE; i++) begin : g_spin
    for (genvar k = 0; k < NUM_SAMPLES; k++) begin : g_smp
      assign w_sample_cap[i*NUM_SAMPLES + k] =
        (r_idx == IDX_W'(k)) ? r_sync2[i] : r_sample[i*NUM_SAMPLES + k];
    end
  end

  // Two-flop synchronizer on every raw spin level.
  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      r_sync1 <= '0;
      r_sync2 <= '0;
    end else begin
      r_sync1 <= SPIN_IN;
      r_sync2 <= r_sync1;
    end
  end

  // Collection FSM. It contains the interval counter, the sample index,
  // the sample register and the registered BUSY/DONE outputs.
  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      r_state  <= S_IDLE;
      r_sample <= '0;
      r_cnt    <= '0;
      r_n      <= '0;
      r_idx    <= '0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
    end else begin
      case (r_state)
        // The DONE cycle accepts START exactly as IDLE does, so that
        // collections can run back to back.
        S_IDLE, S_DONE: begin
          r_done <= 1'b0;
          if (START) begin
            r_state  <= S_WAIT;
            r_busy   <= 1'b1;
            r_sample <= '0;
            r_cnt    <= w_eff_n;
            r_n      <= w_eff_n;
            r_idx    <= '0;
          end else begin
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
          end
        end

        // START is ignored here. A counter value of 1 means this edge is a
        // capture point.
        S_WAIT: begin
          if (r_cnt == c_ONE) begin
            r_sample <= w_sample_cap;
            r_cnt    <= r_n;
            if (r_idx == c_LAST_IDX) begin
              r_state <= S_DONE;
              r_busy  <= 1'b0;
              r_done  <= 1'b1;
              r_idx   <= '0;
            end else begin
              r_idx <= r_idx + 1'b1;
            end
          end else begin
            r_cnt <= r_cnt - c_ONE;
          end
        end

        default: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
          r_done  <= 1'b0;
        end
      endcase
    end
  end

  assign SPIN_SAMPLE = r_sample;
  assign BUSY        = r_busy;
  assign DONE        = r_done;

endmodule

`default_nettype wire

// File: tb/tb_spin_sample_collector.sv
// ============================================================================
// Module   : tb_spin_sample_collector
// Brief    : Directed bench for spin_sample_collector. Each accepted START
//            queues an expected DONE cycle and an expected sample vector.
//            A monitor compares these against every DONE pulse.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_spin_sample_collector;

  localparam int CS = 64;
  localparam int NS = 7;
  localparam int IW = 10;

  logic            CLK = 1'b0;
  logic            RSTN;
  logic            START;
  logic [IW-1:0]   SAMPLE_INTERVAL;
  logic [CS-1:0]   SPIN_IN;
  logic [CS*NS-1:0] SPIN_SAMPLE;
  logic            BUSY;
  logic            DONE;

  spin_sample_collector #(
    .CORE_SIZE  (CS),
    .NUM_SAMPLES(NS),
    .INTERVAL_W (IW)
  ) dut (
    .CLK            (CLK),
    .RSTN           (RSTN),
    .START          (START),
    .SAMPLE_INTERVAL(SAMPLE_INTERVAL),
    .SPIN_IN        (SPIN_IN),
    .SPIN_SAMPLE    (SPIN_SAMPLE),
    .BUSY           (BUSY),
    .DONE           (DONE)
  );

  always #5 CLK = ~CLK;

  // cyc equals the number of rising edges already seen.
  int cyc = 0;
  always @(posedge CLK) cyc <= cyc + 1;

  int total = 0;
  int bad   = 0;

  typedef struct {
    int               due;
    logic [CS*NS-1:0] data;
  } exp_t;
  exp_t sb[$];

  task automatic chk_vec(input string nm, input logic [CS*NS-1:0] act, input logic [CS*NS-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic chk_int(input string nm, input int act, input int exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  function automatic logic [CS*NS-1:0] rep(input logic [CS-1:0] p);
    logic [CS*NS-1:0] r;
    r = '0;
    for (int i = 0; i < CS; i++)
      for (int k = 0; k < NS; k++)
        r[i*NS + k] = p[i];
    return r;
  endfunction

  // Monitor: every DONE pulse must match the oldest queued expectation.
  always @(negedge CLK) begin
    if (RSTN && DONE) begin
      if (sb.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_done: got DONE at cyc %0d expected none", cyc);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk_int("done_cycle", cyc, e.due);
        chk_vec("done_data", SPIN_SAMPLE, e.data);
      end
    end
  end

  // This task is called at a negedge. START is presented to the next rising edge.
  task automatic start_coll(input logic [IW-1:0] n, input logic [CS*NS-1:0] e);
    int   eff;
    exp_t x;
    START           = 1'b1;
    SAMPLE_INTERVAL = n;
    eff             = (n == '0) ? 1 : int'(n);
    x.due           = cyc + 1 + 7 * eff;
    x.data          = e;
    sb.push_back(x);
    @(negedge CLK);
    START = 1'b0;
  endtask

  task automatic drain(input int lim);
    int w;
    w = 0;
    while (sb.size() != 0 && w < lim) begin
      @(negedge CLK);
      w++;
    end
    @(negedge CLK);
    total++;
    if (sb.size() != 0) begin
      bad++;
      $display("FAIL done_timeout: got %0d pending expected 0", sb.size());
      sb.delete();
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [CS*NS-1:0] e2;
    logic [CS-1:0]    pat;
    logic [CS-1:0]    pat2;
    int               t;

    pat  = 64'hA5A5_0F0F_3C3C_9669;
    pat2 = 64'h1234_5678_9ABC_DEF1;

    RSTN            = 1'b1;
    START           = 1'b0;
    SAMPLE_INTERVAL = 10'd3;
    SPIN_IN         = '1;
    #2 RSTN = 1'b0;
    #1;
    chk_vec("reset_sample", SPIN_SAMPLE, '0);
    chk_int("reset_busy", int'(BUSY), 0);
    chk_int("reset_done", int'(DONE), 0);
    repeat (2) @(negedge CLK);
    RSTN = 1'b1;
    repeat (3) @(negedge CLK);

    // 1: all ones, N=3.
    t = cyc + 1;
    start_coll(10'd3, rep('1));
    chk_int("t1_busy_start", int'(BUSY), 1);
    repeat (20) @(negedge CLK);
    chk_int("t1_busy_late", int'(BUSY), 1);
    chk_vec("t1_partial", {{(CS*NS-7){1'b0}}, SPIN_SAMPLE[6:0]}, {{(CS*NS-7){1'b0}}, 7'b0111111});
    @(negedge CLK);
    chk_int("t1_busy_done", int'(BUSY), 0);
    @(negedge CLK);
    chk_vec("t1_hold", SPIN_SAMPLE, rep('1));
    drain(50);

    // 2: only spin 0 high, and it drops to 0 after the third sample point.
    SPIN_IN = 64'h1;
    repeat (3) @(negedge CLK);
    e2 = '0;
    e2[6:0] = 7'b0000111;
    start_coll(10'd2, e2);
    repeat (5) @(negedge CLK);
    SPIN_IN = '0;
    drain(50);

    // 3: interval 0 behaves as 1; then use the maximum interval.
    SPIN_IN = pat;
    repeat (3) @(negedge CLK);
    start_coll(10'd0, rep(pat));
    drain(30);
    SPIN_IN = pat2;
    repeat (3) @(negedge CLK);
    t = cyc + 1;
    start_coll(10'h3FF, rep(pat2));
    while (cyc < t + 1022) @(negedge CLK);
    chk_vec("t3_max_pre", SPIN_SAMPLE, '0);
    @(negedge CLK);
    chk_vec("t3_max_first", {{(CS*NS-7){1'b0}}, SPIN_SAMPLE[6:0]}, {{(CS*NS-1){1'b0}}, pat2[0]});
    drain(8000);

    // 4: START is repulsed mid-collection with a different interval. It must be ignored.
    SPIN_IN = pat;
    repeat (3) @(negedge CLK);
    start_coll(10'd3, rep(pat));
    repeat (4) @(negedge CLK);
    START           = 1'b1;
    SAMPLE_INTERVAL = 10'd9;
    @(negedge CLK);
    START           = 1'b0;
    SAMPLE_INTERVAL = 10'd3;
    drain(50);

    // 5: START is held high with N=1. This gives three back-to-back collections.
    START           = 1'b1;
    SAMPLE_INTERVAL = 10'd0;
    t = cyc + 1;
    for (int j = 0; j < 3; j++) begin
      exp_t x;
      x.due  = t + 7 + 8 * j;
      x.data = rep(pat);
      sb.push_back(x);
    end
    for (int j = 1; j <= 17; j++) begin
      @(negedge CLK);
      if (cyc == t + 8 || cyc == t + 16)
        chk_vec("t5_cleared", SPIN_SAMPLE, '0);
    end
    START = 1'b0;
    drain(30);

    // 6: reset asserted in the middle of an N=3 collection.
    SPIN_IN = '1;
    SAMPLE_INTERVAL = 10'd3;
    repeat (3) @(negedge CLK);
    start_coll(10'd3, rep('1));
    repeat (10) @(negedge CLK);
    chk_vec("t6_pre_reset", {{(CS*NS-7){1'b0}}, SPIN_SAMPLE[6:0]}, {{(CS*NS-7){1'b0}}, 7'b0000111});
    #2 RSTN = 1'b0;
    #1;
    chk_vec("t6_rst_sample", SPIN_SAMPLE, '0);
    chk_int("t6_rst_busy", int'(BUSY), 0);
    chk_int("t6_rst_done", int'(DONE), 0);
    sb.delete();
    repeat (2) @(negedge CLK);
    RSTN = 1'b1;
    repeat (40) @(negedge CLK);
    chk_int("t6_idle_busy", int'(BUSY), 0);
    start_coll(10'd3, rep('1));
    drain(50);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
